// File: rtl/tick_run_control.sv
// rtl/tick_run_control.sv - stopwatch run control: button debounce, RUN/PAUSE/IDLE FSM, tick prescaler
module tick_run_control #(
  parameter int DIV             = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start_stop,
  input  logic btn_clear,
  output logic tick,
  output logic running,
  output logic count_clear_n
);

  localparam int PW = $clog2(DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  // Bit 0 = start/stop, bit 1 = clear throughout the input path.
  logic [1:0]    s1_q, s2_q;
  logic [1:0]    lvl_q, lvl_d;
  logic [1:0]    lvl_prev_q, lvl_prev_d;
  logic [1:0]    evt_q, evt_d;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          running_q, running_d;
  logic          clear_n_q, clear_n_d;

  logic ss_evt, clr_evt;
  assign ss_evt  = evt_q[0];
  assign clr_evt = evt_q[1];

  always_comb begin
    lvl_d      = lvl_q;
    lvl_prev_d = lvl_q;
    evt_d      = lvl_q & ~lvl_prev_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] + DW'(1) == DW'(DEBOUNCE_CYCLES)) begin
          lvl_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      evt_q      <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      s1_q       <= {btn_clear, btn_start_stop};
      s2_q       <= s1_q;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      evt_q      <= evt_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      clear_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      clear_n_q <= clear_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_evt) begin
      state_d = IDLE;
    end else if (ss_evt) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Only cycles spent in RUN with no transition advance the prescaler, so a
  // pause taken at DIV-1 keeps its tick for the resume instead of losing it.
  always_comb begin
    presc_d   = presc_q;
    tick_d    = 1'b0;
    running_d = (state_d == RUN);
    clear_n_d = ~clr_evt;
    if (state_d == IDLE) begin
      presc_d = '0;
    end else if (state_q == RUN && state_d == RUN) begin
      if (presc_q == PW'(DIV - 1)) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  assign tick          = tick_q;
  assign running       = running_q;
  assign count_clear_n = clear_n_q;

endmodule
